// File: rtl/encoder_83_irq.sv
// 8-to-3 priority encoder with sticky request capture, per-bit masking and a
// valid/ready output handshake; cascade pins follow 74x148 conventions.
module encoder_83_irq #(
    parameter bit         EDGE_MODE  = 1'b0,
    parameter logic [7:0] MASK_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EI_n,
    input  logic [7:0] I_n,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       rdy,
    output logic       vld,
    output logic [2:0] A_n,
    output logic       GS_n,
    output logic       EO_n,
    output logic [7:0] pend
);

    logic [7:0] mask;
    logic [7:0] prev_n;
    logic [7:0] set;
    logic [7:0] clr;
    logic [7:0] elig;
    logic [2:0] code;
    logic [2:0] sel;
    logic       any;

    always_comb begin
        set = '0;
        if (!EI_n) set = EDGE_MODE ? (~I_n & prev_n) : ~I_n;
    end

    always_comb begin
        clr = '0;
        if (vld && rdy) clr[code] = 1'b1;
    end

    // The bit being served this edge is excluded so it cannot be re-presented
    // back-to-back even if a fresh set lands on it.
    assign elig = pend & ~clr & ~mask;
    assign any  = |elig;

    always_comb begin
        sel = '0;
        for (int k = 0; k < 8; k++)
            if (elig[k]) sel = 3'(k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= '0;
            mask   <= MASK_RESET;
            prev_n <= 8'hFF;
            vld    <= 1'b0;
            code   <= '0;
            EO_n   <= 1'b1;
        end else begin
            pend   <= (pend & ~clr) | set;
            prev_n <= I_n;
            if (mask_we) mask <= mask_wdata;
            if (EI_n) begin
                vld  <= 1'b0;
                code <= '0;
                EO_n <= 1'b1;
            end else if (!(vld && !rdy)) begin
                // A presented but unaccepted code is held, never preempted.
                vld  <= any;
                code <= sel;
                EO_n <= any;
            end
        end
    end

    assign A_n  = ~code;
    assign GS_n = ~vld;

endmodule

// File: tb/tb_encoder_83_irq.sv
// Bench for encoder_83_irq: level and edge instances run side by side against a
// per-bit behavioural model, with directed scenarios followed by random traffic.
module tb_encoder_83_irq;

    logic       clk = 1'b0;
    logic       rst;
    logic       EI_n;
    logic [7:0] I_n;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       rdy;

    logic [1:0]      vld;
    logic [1:0][2:0] a_n;
    logic [1:0]      gs_n;
    logic [1:0]      eo_n;
    logic [1:0][7:0] pend;

    int checks   = 0;
    int failures = 0;

    // model state, index 0 = level mode, 1 = edge mode
    bit [7:0] m_pend [2];
    bit [7:0] m_mask [2];
    bit [7:0] m_prev [2];
    bit       m_vld  [2];
    int       m_code [2];
    bit       m_eo   [2];

    always #5 clk = ~clk;

    encoder_83_irq #(.EDGE_MODE(1'b0), .MASK_RESET(8'h00)) dut_lvl (
        .clk(clk), .rst(rst), .EI_n(EI_n), .I_n(I_n), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .rdy(rdy), .vld(vld[0]), .A_n(a_n[0]),
        .GS_n(gs_n[0]), .EO_n(eo_n[0]), .pend(pend[0])
    );

    encoder_83_irq #(.EDGE_MODE(1'b1), .MASK_RESET(8'h00)) dut_edg (
        .clk(clk), .rst(rst), .EI_n(EI_n), .I_n(I_n), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .rdy(rdy), .vld(vld[1]), .A_n(a_n[1]),
        .GS_n(gs_n[1]), .EO_n(eo_n[1]), .pend(pend[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs as they stand before it.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_pend[m] = 8'h00;
                m_mask[m] = 8'h00;
                m_prev[m] = 8'hFF;
                m_vld[m]  = 1'b0;
                m_code[m] = 0;
                m_eo[m]   = 1'b1;
            end else begin
                int       served;
                int       best;
                bit [7:0] nxt;
                served = (m_vld[m] && rdy) ? m_code[m] : -1;
                best   = -1;
                nxt    = '0;
                for (int k = 0; k < 8; k++) begin
                    bit still, fresh;
                    still  = m_pend[m][k] && (k != served);
                    fresh  = !EI_n && !I_n[k] && (m == 0 || m_prev[m][k]);
                    nxt[k] = still || fresh;
                    if (still && !m_mask[m][k] && k > best) best = k;
                end
                if (EI_n) begin
                    m_vld[m] = 1'b0; m_code[m] = 0; m_eo[m] = 1'b1;
                end else if (!(m_vld[m] && !rdy)) begin
                    m_vld[m]  = (best >= 0);
                    m_code[m] = (best >= 0) ? best : 0;
                    m_eo[m]   = (best >= 0);
                end
                m_pend[m] = nxt;
                if (mask_we) m_mask[m] = mask_wdata;
                m_prev[m] = I_n;
            end
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            logic [2:0] ea;
            ea = ~3'(m_code[m]);
            chk($sformatf("%s.m%0d.vld", tag, m),  8'(vld[m]),  8'(m_vld[m]));
            chk($sformatf("%s.m%0d.A_n", tag, m),  8'(a_n[m]),  8'(ea));
            chk($sformatf("%s.m%0d.GS_n", tag, m), 8'(gs_n[m]), 8'(!m_vld[m]));
            chk($sformatf("%s.m%0d.EO_n", tag, m), 8'(eo_n[m]), 8'(m_eo[m]));
            chk($sformatf("%s.m%0d.pend", tag, m), pend[m],     m_pend[m]);
        end
    endtask

    initial begin
        int g_lvl, g_edg;
        rst = 1'b1; EI_n = 1'b0; I_n = 8'hFF; mask_we = 1'b0; mask_wdata = 8'h00; rdy = 1'b1;

        // reset and release
        step("rst0");
        step("rst1");
        chk("t1_rst_A_n", 8'(a_n[0]), 8'h07);
        chk("t1_rst_GS_n", 8'(gs_n[0]), 8'h01);
        chk("t1_rst_EO_n", 8'(eo_n[0]), 8'h01);
        rst = 1'b0;
        step("rel");
        chk("t1_EO_n_low", 8'(eo_n[0]), 8'h00);
        chk("t1_vld_low", 8'(vld[0]), 8'h00);

        // three requests served in priority order
        I_n = 8'b0101_1011;
        step("t2a");
        I_n = 8'hFF;
        step("t2b"); chk("t2_code7", 8'(a_n[0]), 8'h00);
        step("t2c"); chk("t2_code5", 8'(a_n[0]), 8'h02);
        step("t2d"); chk("t2_code2", 8'(a_n[0]), 8'h05);
        step("t2e");
        chk("t2_idle_vld", 8'(vld[0]), 8'h00);
        chk("t2_idle_EO_n", 8'(eo_n[0]), 8'h00);
        chk("t2_idle_pend", pend[0], 8'h00);

        // hold without preemption
        rdy = 1'b0; I_n = 8'b1111_0111;
        step("t3a");
        I_n = 8'hFF;
        step("t3b");
        I_n = 8'b1011_1111;
        step("t3c"); chk("t3_hold1", 8'(a_n[0]), 8'h04);
        I_n = 8'hFF;
        step("t3d"); chk("t3_hold2", 8'(a_n[0]), 8'h04);
        rdy = 1'b1;
        step("t3e"); chk("t3_code6", 8'(a_n[0]), 8'h01);
        step("t3f");

        // masking
        mask_we = 1'b1; mask_wdata = 8'h80;
        step("t4a");
        mask_we = 1'b0; I_n = 8'b0111_1101;
        step("t4b");
        I_n = 8'hFF;
        step("t4c"); chk("t4_code1", 8'(a_n[0]), 8'h06);
        step("t4d");
        chk("t4_pend80", pend[0], 8'h80);
        chk("t4_masked_idle", 8'(vld[0]), 8'h00);
        mask_we = 1'b1; mask_wdata = 8'h00;
        step("t4e");
        mask_we = 1'b0;
        step("t4f"); chk("t4_code7", 8'(a_n[0]), 8'h00);
        step("t4g");

        // cascade disable, then reset mid-handshake
        rdy = 1'b0; I_n = 8'b1110_1111;
        step("t5a");
        EI_n = 1'b1; I_n = 8'hFF;
        step("t5b");
        chk("t5_dis_vld", 8'(vld[0]), 8'h00);
        chk("t5_dis_A_n", 8'(a_n[0]), 8'h07);
        chk("t5_dis_EO_n", 8'(eo_n[0]), 8'h01);
        for (int i = 0; i < 3; i++) begin
            I_n = 8'($urandom);
            step("t5c");
        end
        chk("t5_pend_kept", pend[0], 8'h10);
        EI_n = 1'b0; I_n = 8'hFF;
        step("t5d"); chk("t5_code4", 8'(a_n[0]), 8'h03);
        rst = 1'b1;
        step("t5e");
        chk("t5_rst_vld", 8'(vld[0]), 8'h00);
        chk("t5_rst_A_n", 8'(a_n[0]), 8'h07);
        chk("t5_rst_EO_n", 8'(eo_n[0]), 8'h01);
        rst = 1'b0; rdy = 1'b1;
        step("t5f");

        // held-low request: edge mode serves once, level mode keeps re-arming
        g_lvl = 0; g_edg = 0;
        for (int i = 0; i < 9; i++) begin
            I_n = (i < 5) ? 8'hFE : 8'hFF;
            if (vld[0] && rdy) g_lvl++;
            if (vld[1] && rdy) g_edg++;
            step("t6");
        end
        chk("t6_edge_grants", 8'(g_edg), 8'd1);
        chk("t6_level_grants", 8'(g_lvl), 8'd3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            EI_n       = ($urandom_range(0, 9) == 0);
            I_n        = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            rdy        = ($urandom_range(0, 3) != 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 8'($urandom) & 8'($urandom);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
